// File: rtl/fpa_pkg.sv
// rtl/fpa_pkg.sv - shared types and constants for the FPA frame sequencer
//
// Contents:
//   FPA_ROWS / FPA_COLS : sensor geometry (320x240 focal plane)
//   FPA_ROW_W           : row index width
//   FPA_CW              : default width of timing counters and config fields
//   fpa_state_t         : frame sequencer state encoding
package fpa_pkg;
    localparam int FPA_ROWS  = 240;
    localparam int FPA_COLS  = 320;
    localparam int FPA_ROW_W = 8;
    localparam int FPA_CW    = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SYNC,
        ST_ROW,
        ST_DONE,
        ST_BLANK
    } fpa_state_t;
endpackage

// File: rtl/fpa_row_timer.sv
// rtl/fpa_row_timer.sv - per-row cycle counter with registered tc/row_stb and row-end compare
//
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   row_start           : the next cycle is count 0 of a new row
//   row_run             : the next cycle belongs to a row (ROW state)
//   int_time, row_period: latched integration length and row length
//   tc, row_stb         : registered integrate phase / first-cycle-of-row pulse
//   row_end             : current count is the last cycle of the row
module fpa_row_timer
    import fpa_pkg::*;
#(
    parameter int CW = FPA_CW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          row_start,
    input  logic          row_run,
    input  logic [CW-1:0] int_time,
    input  logic [CW-1:0] row_period,
    output logic          tc,
    output logic          row_stb,
    output logic          row_end
);
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_next;

    // A valid config guarantees row_period >= 2, so cnt never reaches the
    // top of the CW range and the +1 cannot wrap.
    always_comb begin
        cnt_next = row_start ? '0 : cnt + CW'(1);
    end

    // tc and row_stb are computed from the count the next cycle will hold,
    // so they line up with cnt while remaining flop outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt     <= '0;
            tc      <= 1'b0;
            row_stb <= 1'b0;
        end else begin
            if (row_run) begin
                cnt <= cnt_next;
            end
            tc      <= row_run && (cnt_next < int_time);
            row_stb <= row_run && row_start;
        end
    end

    assign row_end = (cnt == row_period - CW'(1));
endmodule

// File: rtl/fpa_frame_seq.sv
// rtl/fpa_frame_seq.sv - FPA frame sequencer (sync, row integrate/read, continuous, abort); optional blanking via FPA_SEQ_BLANK_EN
//
// Ports:
//   clk, rst                   : clock, synchronous active-high reset
//   start, cont, abort         : frame request, continuous mode, terminate frame
//   int_time, row_period       : integrate clocks per row, total clocks per row
//   row_first, row_last        : inclusive row window
//   vblank                     : blanking clocks between continuous frames (FPA_SEQ_BLANK_EN only)
//   tc, row_sel, row_stb       : integrate phase, current row, row start pulse
//   f_sync, frame_done         : frame start / frame end pulses
//   busy, cfg_err              : not IDLE, start rejected pulse
module fpa_frame_seq
    import fpa_pkg::*;
#(
    parameter int ROWS = FPA_ROWS,
    parameter int COLS = FPA_COLS,
    parameter int CW   = FPA_CW
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 cont,
    input  logic                 abort,
    input  logic [CW-1:0]        int_time,
    input  logic [CW-1:0]        row_period,
    input  logic [FPA_ROW_W-1:0] row_first,
    input  logic [FPA_ROW_W-1:0] row_last,
`ifdef FPA_SEQ_BLANK_EN
    input  logic [CW-1:0]        vblank,
`endif
    output logic                 tc,
    output logic [FPA_ROW_W-1:0] row_sel,
    output logic                 row_stb,
    output logic                 f_sync,
    output logic                 frame_done,
    output logic                 busy,
    output logic                 cfg_err
);
    if (ROWS < 1 || ROWS > 256 || COLS < 1) begin : g_bad_geometry
        $error("fpa_frame_seq: ROWS must be 1..256 and COLS must be positive");
    end

    fpa_state_t           state, state_n;
    logic [CW-1:0]        sh_int, sh_period;
    logic [FPA_ROW_W-1:0] sh_first, sh_last;
    logic [FPA_ROW_W-1:0] row_sel_n;
    logic                 cfg_ok, latch, cfg_err_n;
    logic                 row_start, row_run, row_end;

    assign cfg_ok = (int_time != '0) && (int_time < row_period) &&
                    (row_first <= row_last) && (int'(row_last) < ROWS);

`ifdef FPA_SEQ_BLANK_EN
    logic [CW-1:0] bcnt;

    // Loaded in DONE so BLANK lasts exactly vblank cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            bcnt <= '0;
        end else if (state == ST_DONE) begin
            bcnt <= vblank - CW'(1);
        end else if (state == ST_BLANK) begin
            bcnt <= bcnt - CW'(1);
        end
    end
`endif

    always_comb begin
        state_n   = state;
        row_sel_n = row_sel;
        latch     = 1'b0;
        cfg_err_n = 1'b0;
        row_start = 1'b0;
        row_run   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    if (cfg_ok) begin
                        state_n = ST_SYNC;
                        latch   = 1'b1;
                    end else begin
                        cfg_err_n = 1'b1;
                    end
                end
            end
            ST_SYNC: begin
                state_n   = ST_ROW;
                row_sel_n = sh_first;
                row_start = 1'b1;
                row_run   = 1'b1;
            end
            ST_ROW: begin
                row_run = 1'b1;
                if (row_end) begin
                    if (row_sel < sh_last) begin
                        row_sel_n = row_sel + 8'd1;
                        row_start = 1'b1;
                    end else begin
                        state_n = ST_DONE;
                        row_run = 1'b0;
                    end
                end
            end
            ST_DONE: begin
                if (cont) begin
                    if (cfg_ok) begin
                        latch = 1'b1;
`ifdef FPA_SEQ_BLANK_EN
                        state_n = (vblank == '0) ? ST_SYNC : ST_BLANK;
`else
                        state_n = ST_SYNC;
`endif
                    end else begin
                        cfg_err_n = 1'b1;
                        state_n   = ST_IDLE;
                    end
                end else begin
                    state_n = ST_IDLE;
                end
            end
`ifdef FPA_SEQ_BLANK_EN
            ST_BLANK: begin
                if (bcnt == '0) begin
                    state_n = ST_SYNC;
                end
            end
`endif
            default: state_n = ST_IDLE;
        endcase

        // Abort overrides everything decided above, including a re-latch.
        if (abort && state != ST_IDLE) begin
            state_n   = ST_IDLE;
            latch     = 1'b0;
            cfg_err_n = 1'b0;
            row_start = 1'b0;
            row_run   = 1'b0;
        end
        if (state_n == ST_IDLE) begin
            row_sel_n = '0;
        end
    end

    // Outputs are registered from the next state so they coincide with it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            sh_int     <= '0;
            sh_period  <= '0;
            sh_first   <= '0;
            sh_last    <= '0;
            row_sel    <= '0;
            f_sync     <= 1'b0;
            frame_done <= 1'b0;
            busy       <= 1'b0;
            cfg_err    <= 1'b0;
        end else begin
            state   <= state_n;
            row_sel <= row_sel_n;
            if (latch) begin
                sh_int    <= int_time;
                sh_period <= row_period;
                sh_first  <= row_first;
                sh_last   <= row_last;
            end
            f_sync     <= (state_n == ST_SYNC);
            frame_done <= (state_n == ST_DONE);
            busy       <= (state_n != ST_IDLE);
            cfg_err    <= cfg_err_n;
        end
    end

    fpa_row_timer #(
        .CW(CW)
    ) u_row_timer (
        .clk       (clk),
        .rst       (rst),
        .row_start (row_start),
        .row_run   (row_run),
        .int_time  (sh_int),
        .row_period(sh_period),
        .tc        (tc),
        .row_stb   (row_stb),
        .row_end   (row_end)
    );
endmodule

// File: doc/fpa_frame_seq.md
# fpa_frame_seq

Frame sequencer for the 320x240 focal-plane readout path. Sits upstream of the row/column shift-register timing generator and drives its `tc` phase input. Each frame it emits one frame sync, then a row-by-row integrate/read pattern over a programmable row window. Supports single-shot and continuous capture, config validation and abort.

## Interface
Parameters:
- `ROWS`, 240: physical row count.
- `COLS`, 320: physical column count (exported only; no counting).
- `CW`, 16: width of timing counters and config fields.

Ports:
- `clk`  in  1: single clock; all state updates on its rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `start`  in  1: request a frame; sampled only in IDLE.
- `cont`  in  1: continuous mode; sampled in DONE.
- `abort`  in  1: terminate current frame.
- `int_time`  in  CW: integration clocks per row (`tc` high).
- `row_period`  in  CW: total clocks per row.
- `row_first`  in  8: first row index of window.
- `row_last`  in  8: last row index of window (inclusive).
- `tc`  out  1: integrate phase of the current row.
- `row_sel`  out  8: current row index.
- `row_stb`  out  1: one-cycle pulse on the first cycle of each row.
- `f_sync`  out  1: one-cycle pulse at frame start.
- `frame_done`  out  1: one-cycle pulse at frame end.
- `busy`  out  1: high in every state except IDLE.
- `cfg_err`  out  1: one-cycle pulse when `start` is rejected.

## Operation
- States: IDLE, SYNC, ROW, DONE (plus BLANK, see Configuration).
- IDLE with `start`=1 and config valid -> SYNC. Config is latched into shadow registers on that edge; later input changes have no effect until the next SYNC entry.
- Config is invalid if `int_time`==0, `int_time`>=`row_period`, `row_first`>`row_last`, or `row_last`>=ROWS. Invalid start: `cfg_err`=1 for one cycle and the FSM stays IDLE.
- SYNC: `f_sync`=1 for one cycle; `row_sel` loads `row_first`; cycle counter clears; -> ROW.
- ROW: cycle counter runs 0..`row_period`-1. `row_stb`=1 at count 0. `tc`=1 while count < `int_time`.
- At count `row_period`-1:
  - `row_sel`<`row_last`: increment `row_sel`, clear counter.
  - otherwise -> DONE.
- DONE: `frame_done`=1 for one cycle. If `cont`=1, re-latch config and -> SYNC (an invalid config gives `cfg_err` and -> IDLE). If `cont`=0 -> IDLE.
- `abort`=1 in any non-IDLE state: -> IDLE next edge; all outputs low, `row_sel`=0; no `frame_done`. `abort` wins over `start`/`cont` on the same cycle.
- `start` while busy is ignored, with no queuing.
- Counter compare uses the full CW width, with no wrap. `row_sel` increment never exceeds `row_last`.

## Timing
- Reset value of every output is 0: `tc`, `row_sel`, `row_stb`, `f_sync`, `frame_done`, `busy`, `cfg_err`. FSM resets to IDLE.
- All outputs are registered. With `start` sampled on edge 0:
  - `f_sync` and `busy` are high in cycle 1.
  - The first `row_stb` and `tc` are high in cycle 2.
- Frame length from `f_sync` to `frame_done` inclusive: N·`row_period`+2 cycles, where N = `row_last`-`row_first`+1.
- Continuous mode without blanking: consecutive `f_sync` pulses are N·`row_period`+2 cycles apart.
- `rst` mid-frame: next cycle all outputs are 0 and the FSM is IDLE.

## Configuration
- `FPA_SEQ_BLANK_EN` defined:
  - Adds input `vblank` (CW).
  - In continuous mode DONE -> BLANK. BLANK holds for `vblank` cycles with `busy`=1 and `tc`=0, then -> SYNC.
  - `vblank`=0 skips BLANK.
  - `abort` in BLANK -> IDLE.
- Not defined: no `vblank` port and no BLANK state; DONE -> SYNC directly.

## Structure
- Shared package `fpa_pkg`:
  - state enum;
  - `FPA_ROWS`=240, `FPA_COLS`=320;
  - row index width 8;
  - the default CW.
- One sub-module, `fpa_row_timer`: the per-row cycle counter plus the `tc`/`row_stb`/row-end compare. The FSM instantiates it.

## Test plan
- Single frame, `int_time`=4, `row_period`=10, rows 0..2, start edge 0 -> `f_sync` cycle 1; `row_stb` cycles 2, 12, 22; `tc` high in cycles 2-5, 12-15, 22-25; `frame_done` cycle 32; `busy` low at cycle 33.
- `int_time`=10, `row_period`=10 -> `cfg_err` for one cycle; `f_sync` and `busy` stay 0.
- Abort at `row_sel`=1, count 2 -> next cycle `tc`=0, `busy`=0, `row_sel`=0; no `frame_done`.
- `cont`=1 over the same config -> second `f_sync` 32 cycles after the first. Drop `cont` mid-frame 2 -> IDLE after its `frame_done`.
- `start` pulsed and `int_time` changed to 7 mid-frame -> no new frame; `tc` stays 4 cycles per row.
- With `FPA_SEQ_BLANK_EN`, `vblank`=5, `cont`=1 -> `f_sync` spacing of 37 cycles; `tc`=0 during blanking.
